// File: rtl/neighbor_sample_filter.sv
// Neighbor sample filter: fetches up to four neighbouring taps from the frame
// buffer, averages them per RGB channel (or passes tap 0 through in bypass),
// and presents the result with its destination write address.
module neighbor_sample_filter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned LINE_WIDTH   = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_req,
  input  logic        filter_en,
  input  logic [10:0] dest_x,
  input  logic [9:0]  dest_y,
  output logic [2:0]  addr_count,
  input  logic [23:0] vram_read_data,
  output logic        busy,
  output logic [23:0] pixel_out,
  output logic        pixel_valid,
  output logic        vram_we,
  output logic [18:0] vram_write_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  logic        filt;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic [1:0]  cnt;
  logic [9:0]  acc_r, acc_g, acc_b;

  // One tag per in-flight read; the oldest stage marks the edge where data is valid.
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_last;

  logic        accept;
  logic        tag_load;
  logic        tag_load_last;
  logic        sample;
  logic        sample_last;
  logic [9:0]  sum_r, sum_g, sum_b;
  logic [18:0] wr_addr;

  // Decode request acceptance, tag issue, tap sampling and next sums.
  always_comb begin
    accept        = (state == IDLE) && pixel_req;
    tag_load      = 1'b0;
    tag_load_last = 1'b0;
    if (accept) begin
      tag_load      = 1'b1;
      tag_load_last = !filter_en;
    end else if ((state == ISSUE) && filt && (cnt != 2'd3)) begin
      tag_load      = 1'b1;
      tag_load_last = (cnt == 2'd2);
    end
    sample      = tag_valid[READ_LATENCY-1];
    sample_last = tag_valid[READ_LATENCY-1] && tag_last[READ_LATENCY-1];
    sum_r   = acc_r + 10'(vram_read_data[23:16]);
    sum_g   = acc_g + 10'(vram_read_data[15:8]);
    sum_b   = acc_b + 10'(vram_read_data[7:0]);
    // Modulo-2^19 arithmetic gives the required truncation directly.
    wr_addr = 19'(x_q) + 19'(y_q) * 19'(LINE_WIDTH);
  end

  // Control FSM, tag pipeline, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      filt            <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      cnt             <= '0;
      acc_r           <= '0;
      acc_g           <= '0;
      acc_b           <= '0;
      tag_valid       <= '0;
      tag_last        <= '0;
      busy            <= 1'b0;
      pixel_out       <= '0;
      pixel_valid     <= 1'b0;
      vram_write_addr <= '0;
    end else begin
      pixel_valid <= 1'b0;

      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      tag_valid[0] <= tag_load;
      tag_last[0]  <= tag_load_last;

      case (state)
        IDLE: begin
          if (pixel_req) begin
            filt  <= filter_en;
            x_q   <= dest_x;
            y_q   <= dest_y;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (filt && (cnt != 2'd3)) begin
            cnt <= cnt + 2'd1;
          end else begin
            cnt   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: state <= DRAIN;
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The final tap can land while still issuing (READ_LATENCY=1), so it overrides the FSM step.
      if (sample) begin
        acc_r <= sum_r;
        acc_g <= sum_g;
        acc_b <= sum_b;
        if (sample_last) begin
          pixel_out       <= filt ? {sum_r[9:2], sum_g[9:2], sum_b[9:2]} : vram_read_data;
          vram_write_addr <= wr_addr;
          pixel_valid     <= 1'b1;
          cnt             <= '0;
          state           <= DONE;
        end
      end
    end
  end

  assign addr_count = {1'b0, cnt};
  assign vram_we    = pixel_valid;

endmodule

// File: tb/tb_neighbor_sample_filter.sv
// Directed and randomized bench for neighbor_sample_filter at read latencies 2, 1 and 6.
module tb_neighbor_sample_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fen;
  logic [10:0] dx;
  logic [9:0]  dy;
  logic        pr [3];
  logic [23:0] rd [3];
  logic [2:0]  ac [3];
  logic        bz [3];
  logic        pv [3];
  logic        we [3];
  logic [23:0] po [3];
  logic [18:0] wa [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neighbor_sample_filter #(.READ_LATENCY(2), .LINE_WIDTH(800)) dut0 (
    .clk(clk), .reset(reset), .pixel_req(pr[0]), .filter_en(fen), .dest_x(dx), .dest_y(dy),
    .addr_count(ac[0]), .vram_read_data(rd[0]), .busy(bz[0]), .pixel_out(po[0]),
    .pixel_valid(pv[0]), .vram_we(we[0]), .vram_write_addr(wa[0]));

  neighbor_sample_filter #(.READ_LATENCY(1), .LINE_WIDTH(800)) dut1 (
    .clk(clk), .reset(reset), .pixel_req(pr[1]), .filter_en(fen), .dest_x(dx), .dest_y(dy),
    .addr_count(ac[1]), .vram_read_data(rd[1]), .busy(bz[1]), .pixel_out(po[1]),
    .pixel_valid(pv[1]), .vram_we(we[1]), .vram_write_addr(wa[1]));

  neighbor_sample_filter #(.READ_LATENCY(6), .LINE_WIDTH(800)) dut2 (
    .clk(clk), .reset(reset), .pixel_req(pr[2]), .filter_en(fen), .dest_x(dx), .dest_y(dy),
    .addr_count(ac[2]), .vram_read_data(rd[2]), .busy(bz[2]), .pixel_out(po[2]),
    .pixel_valid(pv[2]), .vram_we(we[2]), .vram_write_addr(wa[2]));

  function automatic int lat(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 6;
    endcase
  endfunction

  // Reference: per-channel mean of four taps with truncation, or tap 0 in bypass.
  function automatic logic [23:0] ref_pixel(input bit f, input logic [3:0][23:0] taps);
    logic [23:0] res;
    int sum;
    if (!f) return taps[0];
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) sum += int'(taps[k][ch*8 +: 8]);
      res[ch*8 +: 8] = 8'(sum / 4);
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input int d, input string tag);
    chk({tag, " busy"}, 32'(bz[d]), 32'd0);
    chk({tag, " valid"}, 32'(pv[d]), 32'd0);
    chk({tag, " we"}, 32'(we[d]), 32'd0);
    chk({tag, " addr_count"}, 32'(ac[d]), 32'd0);
    chk({tag, " pixel_out"}, 32'(po[d]), 32'd0);
    chk({tag, " write_addr"}, 32'(wa[d]), 32'd0);
  endtask

  // Issue one request on DUT d and check every cycle until it is idle again.
  // Read data is correct only on the edges where the tap is due; otherwise random.
  task automatic do_pixel(input int d, input bit f, input int x, input int y,
                          input logic [3:0][23:0] taps, input string tag);
    int rl;
    int fin;
    int exp_ac;
    logic [23:0] exp_pix;
    logic [18:0] exp_addr;
    rl       = lat(d);
    fin      = f ? 3 + rl : rl;
    exp_pix  = ref_pixel(f, taps);
    exp_addr = 19'(x + y * 800);
    for (int n = 0; n <= fin + 1; n++) begin
      @(negedge clk);
      pr[d] = (n == 0);
      if (n == 0) begin
        fen = f;
        dx  = 11'(x);
        dy  = 10'(y);
      end else begin
        fen = 1'($urandom);
        dx  = 11'($urandom);
        dy  = 10'($urandom);
      end
      if (f && n >= rl && n - rl <= 3) rd[d] = taps[n - rl];
      else if (!f && n == rl)          rd[d] = taps[0];
      else                             rd[d] = 24'($urandom);
      @(posedge clk);
      #1;
      exp_ac = (f && n <= 3) ? n : 0;
      chk($sformatf("%s addr_count c%0d", tag, n), 32'(ac[d]), 32'(exp_ac));
      chk($sformatf("%s busy c%0d", tag, n), 32'(bz[d]), 32'(n <= fin));
      chk($sformatf("%s valid c%0d", tag, n), 32'(pv[d]), 32'(n == fin));
      chk($sformatf("%s we c%0d", tag, n), 32'(we[d]), 32'(n == fin));
      if (n == fin) begin
        chk({tag, " pixel_out"}, 32'(po[d]), 32'(exp_pix));
        chk({tag, " write_addr"}, 32'(wa[d]), 32'(exp_addr));
      end
    end
  endtask

  initial begin
    logic [3:0][23:0] taps;
    for (int d = 0; d < 3; d++) begin
      pr[d] = 1'b0;
      rd[d] = '0;
    end
    fen   = 1'b0;
    dx    = '0;
    dy    = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_reset_state(d, $sformatf("reset d%0d", d));
    @(negedge clk);
    reset = 1'b0;

    // Averaging example
    taps = {24'h405060, 24'h304050, 24'h203040, 24'h102030};
    do_pixel(0, 1'b1, 10, 2, taps, "avg");

    // Saturated channels truncate without wrapping
    taps = {24'hFEFEFE, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    do_pixel(0, 1'b1, 0, 0, taps, "trunc");

    // Bypass at the last pixel of the frame
    taps = {24'h111111, 24'h222222, 24'h333333, 24'hABCDEF};
    do_pixel(0, 1'b0, 799, 599, taps, "bypass");

    // Latency sweep, directed
    taps = {24'h0A0B0C, 24'h334455, 24'h80FF01, 24'h123456};
    do_pixel(1, 1'b1, 5, 7, taps, "lat1");
    do_pixel(2, 1'b1, 2047, 1023, taps, "lat6");
    do_pixel(1, 1'b0, 3, 4, taps, "lat1 bypass");
    do_pixel(2, 1'b0, 100, 200, taps, "lat6 bypass");

    // Held request: one result every 7 cycles, one idle cycle between
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      pr[0] = 1'b1;
      fen   = 1'b1;
      rd[0] = 24'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("held valid c%0d", n), 32'(pv[0]), 32'((n % 7) == 5));
      chk($sformatf("held busy c%0d", n), 32'(bz[0]), 32'((n % 7) != 6));
    end
    @(negedge clk);
    pr[0] = 1'b0;

    // Reset one cycle after E2 of a filtered request
    taps = {24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F};
    for (int n = 0; n <= 2; n++) begin
      @(negedge clk);
      pr[0] = (n == 0);
      fen   = 1'b1;
      dx    = 11'd9;
      dy    = 10'd9;
      rd[0] = (n >= 2) ? taps[n - 2] : 24'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("pre-reset addr_count c%0d", n), 32'(ac[0]), 32'(n));
    end
    @(negedge clk);
    reset = 1'b1;
    rd[0] = 24'hFFFFFF;
    @(posedge clk);
    #1;
    chk_reset_state(0, "mid reset");
    @(negedge clk);
    pr[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("reset beats request busy", 32'(bz[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pr[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      rd[0] = 24'hFFFFFF;
      @(posedge clk);
      #1;
      chk($sformatf("post-reset valid c%0d", n), 32'(pv[0]), 32'd0);
      chk($sformatf("post-reset busy c%0d", n), 32'(bz[0]), 32'd0);
    end
    taps = {24'h040404, 24'h030303, 24'h020202, 24'h010101};
    do_pixel(0, 1'b1, 1, 1, taps, "after reset");

    // Randomized requests across all three latencies
    for (int i = 0; i < 12; i++) begin
      int d;
      d = int'($urandom_range(0, 2));
      for (int k = 0; k < 4; k++) taps[k] = 24'($urandom);
      do_pixel(d, 1'($urandom), int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
               taps, $sformatf("rand%0d d%0d", i, d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
